// File: rtl/sudoku_input_ctrl.sv
// Button conditioning (2-flop sync + debounce + press pulse), cursor, and the
// authoritative 9x9 cell/given array feeding the display controller.
module sudoku_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RESET_ROW       = 4,
    parameter int RESET_COL       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cursor_down_n,
    input  logic                  cursor_right_n,
    input  logic                  place_n,
    input  logic [3:0]            num_select,
    input  logic                  load_en,
    input  logic [3:0]            load_row,
    input  logic [3:0]            load_col,
    input  logic [3:0]            load_value,
    input  logic                  clear_all,
    output logic [3:0]            cursor_row,
    output logic [3:0]            cursor_col,
    output logic [8:0][8:0][3:0]  display_grid,
    output logic [8:0][8:0]       given_mask,
    output logic                  place_ok,
    output logic                  place_reject
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Button index: 0 = down, 1 = right, 2 = place
    logic [2:0]          raw;
    logic [2:0]          sync1_q, sync2_q, deb_q, deb_dly_q, arm_q, press_q;
    logic [2:0][CW-1:0]  cnt_q;
    logic [1:0]          settle_q;

    assign raw = {place_n, cursor_right_n, cursor_down_n};

    // A button only starts debouncing once it has been seen released after
    // the synchronizer has settled, so a button held through reset cannot
    // generate a press until it is released and pressed again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            deb_dly_q <= '1;
            arm_q     <= '0;
            press_q   <= '0;
            cnt_q     <= '0;
            settle_q  <= '0;
        end else begin
            settle_q  <= {settle_q[0], 1'b1};
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            press_q   <= deb_dly_q & ~deb_q;
            for (int b = 0; b < 3; b++) begin
                if (!arm_q[b]) begin
                    arm_q[b] <= settle_q[1] & sync2_q[b];
                    cnt_q[b] <= '0;
                end else if (sync2_q[b] == deb_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CNT_MAX) begin
                    deb_q[b] <= sync2_q[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + 1'b1;
                end
            end
        end
    end

    logic                 down_ev, right_ev, place_ev;
    logic                 load_ok, load_same_cell;
    logic [3:0]           row_q, col_q;
    logic [8:0][8:0][3:0] grid_q;
    logic [8:0][8:0]      mask_q;
    logic                 ok_q, rej_q;

    assign down_ev  = press_q[0];
    assign right_ev = press_q[1];
    assign place_ev = press_q[2];

    assign load_ok        = load_en && (load_row <= 4'd8) && (load_col <= 4'd8)
                            && (load_value <= 4'd9);
    assign load_same_cell = load_ok && (load_row == row_q) && (load_col == col_q);

    // Placement sees the pre-move cursor; clear_all > load > place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q  <= 4'(RESET_ROW);
            col_q  <= 4'(RESET_COL);
            grid_q <= '0;
            mask_q <= '0;
            ok_q   <= 1'b0;
            rej_q  <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            rej_q <= 1'b0;
            if (down_ev)
                row_q <= (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
            if (right_ev)
                col_q <= (col_q == 4'd8) ? 4'd0 : col_q + 4'd1;
            if (clear_all) begin
                grid_q <= '0;
                mask_q <= '0;
                rej_q  <= place_ev;
            end else begin
                if (load_ok) begin
                    grid_q[load_row][load_col] <= load_value;
                    mask_q[load_row][load_col] <= (load_value != 4'd0);
                end
                if (place_ev) begin
                    if ((num_select > 4'd9) || mask_q[row_q][col_q] || load_same_cell) begin
                        rej_q <= 1'b1;
                    end else begin
                        grid_q[row_q][col_q] <= num_select;
                        ok_q                 <= 1'b1;
                    end
                end
            end
        end
    end

    assign cursor_row   = row_q;
    assign cursor_col   = col_q;
    assign display_grid = grid_q;
    assign given_mask   = mask_q;
    assign place_ok     = ok_q;
    assign place_reject = rej_q;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// Directed bench for sudoku_input_ctrl with a short debounce window.
module tb_sudoku_input_ctrl;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           btn_n;
    logic [3:0]           num_select;
    logic                 load_en;
    logic [3:0]           load_row, load_col, load_value;
    logic                 clear_all;
    logic [3:0]           cursor_row, cursor_col;
    logic [8:0][8:0][3:0] display_grid;
    logic [8:0][8:0]      given_mask;
    logic                 place_ok, place_reject;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int rej_cnt = 0;
    int ok0, rej0;

    always #5 clk = ~clk;

    sudoku_input_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_ROW(4), .RESET_COL(4)) dut (
        .clk(clk), .reset(reset),
        .cursor_down_n(btn_n[0]), .cursor_right_n(btn_n[1]), .place_n(btn_n[2]),
        .num_select(num_select),
        .load_en(load_en), .load_row(load_row), .load_col(load_col), .load_value(load_value),
        .clear_all(clear_all),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .display_grid(display_grid), .given_mask(given_mask),
        .place_ok(place_ok), .place_reject(place_reject)
    );

    always @(negedge clk) begin
        if (place_ok === 1'b1) ok_cnt++;
        if (place_reject === 1'b1) rej_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int nz_cells();
        int n = 0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                if (display_grid[r][c] != 4'd0) n++;
        return n;
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(5);
    endtask

    task automatic press(input int b);
        btn_n[b] = 1'b0;
        ticks(10);
        btn_n[b] = 1'b1;
        ticks(10);
    endtask

    // Place press; the strobes are driven in the cycle the place event is applied.
    task automatic place(input logic do_clear, input logic do_load,
                         input logic [3:0] r, input logic [3:0] c, input logic [3:0] v);
        ok0  = ok_cnt;
        rej0 = rej_cnt;
        btn_n[2] = 1'b0;
        ticks(7);
        clear_all  = do_clear;
        load_en    = do_load;
        load_row   = r;
        load_col   = c;
        load_value = v;
        ticks(1);
        clear_all = 1'b0;
        load_en   = 1'b0;
        ticks(2);
        btn_n[2] = 1'b1;
        ticks(10);
    endtask

    task automatic load(input logic [3:0] r, input logic [3:0] c, input logic [3:0] v);
        load_row = r; load_col = c; load_value = v; load_en = 1'b1;
        ticks(1);
        load_en = 1'b0;
        ticks(1);
    endtask

    initial begin
        reset = 1'b1; btn_n = 3'b111; num_select = 4'd0; load_en = 1'b0;
        load_row = 4'd0; load_col = 4'd0; load_value = 4'd0; clear_all = 1'b0;

        // Reset state
        ticks(2);
        reset = 1'b0;
        ticks(5);
        chk("rst_row", cursor_row, 4);
        chk("rst_col", cursor_col, 4);
        chk("rst_cells", nz_cells(), 0);
        chk("rst_mask", $countones(given_mask), 0);
        chk("rst_ok", place_ok, 0);
        chk("rst_rej", place_reject, 0);

        // Held down: press at edge 7, cursor moves on edge 8, once only
        btn_n[0] = 1'b0;
        ticks(7);
        chk("dn_edge7", cursor_row, 4);
        ticks(1);
        chk("dn_edge8", cursor_row, 5);
        ticks(12);
        chk("dn_hold", cursor_row, 5);
        btn_n[0] = 1'b1;
        ticks(10);
        chk("dn_release", cursor_row, 5);
        for (int i = 0; i < 5; i++) press(0);
        chk("dn_wrap", cursor_row, 1);
        chk("dn_col", cursor_col, 4);

        // Bounce on right must be ignored, then one step on a stable hold
        for (int i = 0; i < 5; i++) begin
            btn_n[1] = 1'b0;
            ticks(3);
            btn_n[1] = 1'b1;
            ticks(1);
        end
        ticks(6);
        chk("rt_bounce", cursor_col, 4);
        btn_n[1] = 1'b0;
        ticks(12);
        btn_n[1] = 1'b1;
        ticks(10);
        chk("rt_hold", cursor_col, 5);

        // Placement at (4,4)
        do_reset();
        num_select = 4'd7;
        place(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("pl7_cell", display_grid[4][4], 7);
        chk("pl7_ok", ok_cnt - ok0, 1);
        chk("pl7_rej", rej_cnt - rej0, 0);
        num_select = 4'd12;
        place(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("pl12_rej", rej_cnt - rej0, 1);
        chk("pl12_ok", ok_cnt - ok0, 0);
        chk("pl12_cell", display_grid[4][4], 7);

        // Givens
        load(4'd2, 4'd3, 4'd5);
        chk("ld_cell", display_grid[2][3], 5);
        chk("ld_mask", given_mask[2][3], 1);
        load(4'd9, 4'd3, 4'd1);
        load(4'd2, 4'd9, 4'd1);
        load(4'd0, 4'd0, 4'd10);
        chk("ld_oor_cell", display_grid[0][0], 0);
        chk("ld_oor_count", nz_cells(), 2);
        chk("ld_oor_mask", $countones(given_mask), 1);
        for (int i = 0; i < 7; i++) press(0);
        for (int i = 0; i < 8; i++) press(1);
        chk("mv_row", cursor_row, 2);
        chk("mv_col", cursor_col, 3);
        num_select = 4'd9;
        place(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("given_rej", rej_cnt - rej0, 1);
        chk("given_cell", display_grid[2][3], 5);
        load(4'd2, 4'd3, 4'd0);
        chk("unld_mask", given_mask[2][3], 0);
        chk("unld_cell", display_grid[2][3], 0);
        place(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("ungiven_ok", ok_cnt - ok0, 1);
        chk("ungiven_cell", display_grid[2][3], 9);

        // Same-cycle load: other cell does not block, same cell does
        num_select = 4'd2;
        place(1'b0, 1'b1, 4'd0, 4'd0, 4'd8);
        chk("ldo_ok", ok_cnt - ok0, 1);
        chk("ldo_cell", display_grid[2][3], 2);
        chk("ldo_lcell", display_grid[0][0], 8);
        chk("ldo_lmask", given_mask[0][0], 1);
        num_select = 4'd3;
        place(1'b0, 1'b1, 4'd2, 4'd3, 4'd6);
        chk("lds_rej", rej_cnt - rej0, 1);
        chk("lds_ok", ok_cnt - ok0, 0);
        chk("lds_cell", display_grid[2][3], 6);
        chk("lds_mask", given_mask[2][3], 1);

        // clear_all pre-empts a place
        num_select = 4'd4;
        place(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("clr_rej", rej_cnt - rej0, 1);
        chk("clr_ok", ok_cnt - ok0, 0);
        chk("clr_cells", nz_cells(), 0);
        chk("clr_mask", $countones(given_mask), 0);
        chk("clr_row", cursor_row, 2);
        chk("clr_col", cursor_col, 3);

        // Reset mid-debounce, button released during reset
        btn_n[0] = 1'b0;
        ticks(4);
        reset = 1'b1;
        ticks(1);
        btn_n[0] = 1'b1;
        ticks(1);
        reset = 1'b0;
        ticks(20);
        chk("rmid_row", cursor_row, 4);
        chk("rmid_col", cursor_col, 4);

        // Button held through reset deassertion: no press until re-press
        btn_n[0] = 1'b0;
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(20);
        chk("rheld_row", cursor_row, 4);
        btn_n[0] = 1'b1;
        ticks(10);
        chk("rheld_rel", cursor_row, 4);
        press(0);
        chk("rheld_repress", cursor_row, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
